// File: rtl/hazard_scoreboard.sv
// Purpose: ID-stage hazard scoreboard; tracks pending multi-cycle writes per int/FP register and stalls on RAW/WAW.
// Latency: stall_id/issue_id are combinational from current counters and ID inputs; counters update on the next clock.
// Backpressure: stall_id holds PC and IF/ID and bubbles ID/EX; flush_id suppresses issue and stall for the ID slot only.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 2,
    parameter int FPU_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_id,
    input  logic        flush_id,
    input  logic [4:0]  rd_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic        rs1_fpu_id,
    input  logic        rs2_fpu_id,
    input  logic [1:0]  regwrite_id,
    input  logic        memread_id,
    input  logic [1:0]  alu_op_id,
    output logic        stall_id,
    output logic        issue_id,
    output logic [31:0] busy_int,
    output logic [31:0] busy_fp
);

    localparam int MAXL = (LOAD_LAT > FPU_LAT) ? LOAD_LAT : FPU_LAT;
    localparam int CW   = $clog2(MAXL) + 1;
    localparam logic [CW-1:0] LD_M1 = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] FP_M1 = CW'(FPU_LAT - 1);

    // Remaining cycles until each register's pending result becomes forwardable
    logic [CW-1:0] cnt_int [32];
    logic [CW-1:0] cnt_fp  [32];

    logic [CW-1:0] lat_m1;
    logic [CW-1:0] src1_cnt;
    logic [CW-1:0] src2_cnt;
    logic          tracked;
    logic          dst_int;
    logic          dst_fp;
    logic          raw1;
    logic          raw2;
    logic          waw;
    logic          go;

    // x0 is hardwired, so an integer write to it is never tracked
    assign dst_int = (regwrite_id == 2'b01) && (rd_id != 5'd0);
    assign dst_fp  = (regwrite_id == 2'b10);

    // Latency class (L-1) of the ID instruction and hazard detection against current counters
    always_comb begin
        lat_m1 = '0;
        if (memread_id) begin
            lat_m1 = LD_M1;
        end else if (alu_op_id == 2'b11) begin
            lat_m1 = FP_M1;
        end
        tracked  = (lat_m1 != '0);
        src1_cnt = rs1_fpu_id ? cnt_fp[rs1_id] : cnt_int[rs1_id];
        src2_cnt = rs2_fpu_id ? cnt_fp[rs2_id] : cnt_int[rs2_id];
        raw1     = rs1_used_id && (src1_cnt != '0) && (rs1_fpu_id || (rs1_id != 5'd0));
        raw2     = rs2_used_id && (src2_cnt != '0) && (rs2_fpu_id || (rs2_id != 5'd0));
        // A younger write must not complete before an older pending write to the same register
        waw      = (dst_int && (cnt_int[rd_id] > lat_m1)) ||
                   (dst_fp  && (cnt_fp[rd_id]  > lat_m1));
    end

    assign go       = valid_id && !flush_id && !rst;
    assign stall_id = go && (raw1 || raw2 || waw);
    assign issue_id = go && !stall_id;

    // Countdown every pending entry; a newly issued multi-cycle producer reloads its destination
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_int[i] <= '0;
                cnt_fp[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (issue_id && tracked && dst_int && (rd_id == 5'(i))) begin
                    cnt_int[i] <= lat_m1;
                end else if (cnt_int[i] != '0) begin
                    cnt_int[i] <= cnt_int[i] - CW'(1);
                end
                if (issue_id && tracked && dst_fp && (rd_id == 5'(i))) begin
                    cnt_fp[i] <= lat_m1;
                end else if (cnt_fp[i] != '0) begin
                    cnt_fp[i] <= cnt_fp[i] - CW'(1);
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < 32; g++) begin : g_busy
            assign busy_int[g] = (cnt_int[g] != '0);
            assign busy_fp[g]  = (cnt_fp[g]  != '0);
        end
    endgenerate

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: randomized + directed bench for hazard_scoreboard against a ready-time reference model.
// Latency: expected outputs are per-cycle combinational; the monitor compares at each falling edge.
// Backpressure: stall/issue outcomes feed back into the model's issue decisions.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 2;
    localparam int FPU_LAT  = 4;

    logic        clk = 1'b0;
    logic        rst, valid_id, flush_id;
    logic [4:0]  rd_id, rs1_id, rs2_id;
    logic        rs1_used_id, rs2_used_id, rs1_fpu_id, rs2_fpu_id;
    logic [1:0]  regwrite_id, alu_op_id;
    logic        memread_id;
    logic        stall_id, issue_id;
    logic [31:0] busy_int, busy_fp;

    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .FPU_LAT(FPU_LAT)) dut (
        .clk(clk), .rst(rst), .valid_id(valid_id), .flush_id(flush_id),
        .rd_id(rd_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rs1_fpu_id(rs1_fpu_id), .rs2_fpu_id(rs2_fpu_id),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .alu_op_id(alu_op_id),
        .stall_id(stall_id), .issue_id(issue_id), .busy_int(busy_int), .busy_fp(busy_fp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, valid, flush;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, f1, f2;
        logic [1:0] rw;
        logic       mr;
        logic [1:0] ao;
    } in_t;

    typedef struct {
        logic        stall, issue;
        logic [31:0] bint, bfp;
        int          fixed;   // -1: no directed expectation on stall_id
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: absolute cycle at which each register's result becomes forwardable
    int ready_int[32];
    int ready_fp[32];
    int now = 0;

    function automatic in_t nop();
        in_t s;
        s = '0;
        s.valid = 1'b1;
        return s;
    endfunction

    task automatic step(input in_t s, input int fixed, input string tag);
        exp_t e;
        int   lat;
        bit   di, df, raw1, raw2, waw, go;
        rst = s.rst; valid_id = s.valid; flush_id = s.flush;
        rd_id = s.rd; rs1_id = s.rs1; rs2_id = s.rs2;
        rs1_used_id = s.u1; rs2_used_id = s.u2; rs1_fpu_id = s.f1; rs2_fpu_id = s.f2;
        regwrite_id = s.rw; memread_id = s.mr; alu_op_id = s.ao;

        lat  = s.mr ? LOAD_LAT : ((s.ao == 2'b11) ? FPU_LAT : 1);
        di   = (s.rw == 2'b01) && (s.rd != 0);
        df   = (s.rw == 2'b10);
        raw1 = s.u1 && (s.f1 ? (ready_fp[s.rs1] > now) : (s.rs1 != 0 && ready_int[s.rs1] > now));
        raw2 = s.u2 && (s.f2 ? (ready_fp[s.rs2] > now) : (s.rs2 != 0 && ready_int[s.rs2] > now));
        waw  = (di && ready_int[s.rd] > now + lat - 1) || (df && ready_fp[s.rd] > now + lat - 1);
        go   = s.valid && !s.flush && !s.rst;
        e.stall = go && (raw1 || raw2 || waw);
        e.issue = go && !e.stall;
        for (int i = 0; i < 32; i++) begin
            e.bint[i] = ready_int[i] > now;
            e.bfp[i]  = ready_fp[i] > now;
        end
        e.fixed = fixed;
        e.tag   = tag;
        exp_q.push_back(e);

        @(posedge clk);
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin
                ready_int[i] = 0;
                ready_fp[i]  = 0;
            end
        end else if (e.issue && lat >= 2) begin
            if (di) ready_int[s.rd] = now + 1 + lat - 1;
            if (df) ready_fp[s.rd]  = now + 1 + lat - 1;
        end
        now++;
        #1;
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (stall_id !== e.stall) begin
                failures++;
                $display("FAIL %s stall_id got=%b want=%b t=%0t", e.tag, stall_id, e.stall, $time);
            end
            if (issue_id !== e.issue) begin
                failures++;
                $display("FAIL %s issue_id got=%b want=%b t=%0t", e.tag, issue_id, e.issue, $time);
            end
            if (busy_int !== e.bint) begin
                failures++;
                $display("FAIL %s busy_int got=%h want=%h t=%0t", e.tag, busy_int, e.bint, $time);
            end
            if (busy_fp !== e.bfp) begin
                failures++;
                $display("FAIL %s busy_fp got=%h want=%h t=%0t", e.tag, busy_fp, e.bfp, $time);
            end
            if (e.fixed >= 0) begin
                checks++;
                if (stall_id !== e.fixed[0]) begin
                    failures++;
                    $display("FAIL %s directed stall got=%b want=%0d t=%0t", e.tag, stall_id, e.fixed, $time);
                end
            end
        end
    end

    initial begin
        in_t s;
        for (int i = 0; i < 32; i++) begin
            ready_int[i] = 0;
            ready_fp[i]  = 0;
        end
        s = nop();
        s.rst = 1'b1;
        rst = 1'b1; valid_id = 1'b1; flush_id = 1'b0; rd_id = 5; rs1_id = 5; rs2_id = 0;
        rs1_used_id = 1'b1; rs2_used_id = 1'b0; rs1_fpu_id = 1'b0; rs2_fpu_id = 1'b0;
        regwrite_id = 2'b01; memread_id = 1'b1; alu_op_id = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with valid hazard-shaped instructions
        s = nop(); s.rst = 1; s.rd = 5; s.rw = 2'b01; s.mr = 1;        step(s, 0, "rst_lw");
        s = nop(); s.rst = 1; s.rs1 = 5; s.u1 = 1; s.rw = 2'b01; s.rd = 6; step(s, 0, "rst_use");
        s = nop();                                                      step(s, 0, "post_rst");

        // Load-use
        s = nop(); s.rd = 5; s.rw = 2'b01; s.mr = 1;                    step(s, 0, "lw_x5");
        s = nop(); s.rd = 6; s.rw = 2'b01; s.rs1 = 5; s.u1 = 1;         step(s, 1, "use_t1");
        step(s, 0, "use_t2");

        // FPU chain on rs2, then an integer-file reader of x3
        s = nop(); s.rd = 3; s.rw = 2'b10; s.ao = 2'b11;                step(s, 0, "fadd_f3");
        s = nop(); s.rd = 9; s.rw = 2'b10; s.ao = 2'b11; s.rs2 = 3; s.u2 = 1; s.f2 = 1;
        step(s, 1, "fmul_t1"); step(s, 1, "fmul_t2"); step(s, 1, "fmul_t3"); step(s, 0, "fmul_t4");
        s = nop(); s.rd = 3; s.rw = 2'b10; s.ao = 2'b11;                step(s, 0, "fadd_f3b");
        s = nop(); s.rd = 10; s.rw = 2'b01; s.rs2 = 3; s.u2 = 1;        step(s, 0, "int_x3");

        // WAW: flw behind a pending fadd to the same FP register
        s = nop(); s.rd = 7; s.rw = 2'b10; s.ao = 2'b11;                step(s, 0, "fadd_f7");
        s = nop(); s.rd = 7; s.rw = 2'b10; s.mr = 1;
        step(s, 1, "flw_t1"); step(s, 1, "flw_t2"); step(s, 0, "flw_t3");

        // x0 destination, then flushed hazard with an older pending counter
        s = nop(); s.rd = 0; s.rw = 2'b01; s.mr = 1;                    step(s, 0, "lw_x0");
        s = nop(); s.rs1 = 0; s.u1 = 1;                                 step(s, 0, "rd_x0");
        s = nop(); s.rd = 1; s.rw = 2'b10; s.ao = 2'b11;                step(s, 0, "fadd_f1");
        s = nop(); s.flush = 1; s.rs1 = 1; s.u1 = 1; s.f1 = 1;          step(s, 0, "flush_t1");
        step(s, 0, "flush_t2");

        // Reset mid-flight
        s = nop(); s.rd = 2; s.rw = 2'b10; s.ao = 2'b11;                step(s, 0, "fadd_f2");
        s = nop(); s.rst = 1;                                           step(s, 0, "mid_rst");
        s = nop(); s.rd = 4; s.rw = 2'b10; s.rs1 = 2; s.u1 = 1; s.f1 = 1; step(s, 0, "after_rst");

        // Randomized traffic over a small register window to provoke frequent hazards
        for (int n = 0; n < 3000; n++) begin
            s       = '0;
            s.rst   = ($urandom_range(0, 99) < 2);
            s.valid = ($urandom_range(0, 9) != 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.rd    = 5'($urandom_range(0, 7));
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs2   = 5'($urandom_range(0, 7));
            s.u1    = 1'($urandom);
            s.u2    = 1'($urandom);
            s.f1    = 1'($urandom);
            s.f2    = 1'($urandom);
            s.rw    = 2'($urandom);
            s.mr    = ($urandom_range(0, 9) < 3);
            s.ao    = 2'($urandom);
            step(s, -1, "rand");
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer side of the ID-stage control word. It takes the decoded control fields (regwrite, memread, alu_op, rs1/rs2 FPU select) plus register indices for each instruction in ID.
- It tracks in-flight multi-cycle results (loads, FPU ops) per destination register in the integer and FP register files.
- It raises `stall_id` on RAW and WAW hazards; single-cycle ALU results are left to forwarding.
- It sits beside the ID/EX pipeline register and drives the PC and IF/ID hold enables.

Parameters:
- LOAD_LAT, 2, cycles from load issue until its result is forwardable; must be >= 1.
- FPU_LAT, 4, cycles from FPU-op issue until its result is forwardable; must be >= 1.
- CW, $clog2(max(LOAD_LAT,FPU_LAT))+1, per-register countdown width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_id  in  1  ID stage holds a real instruction
- flush_id  in  1  ID instruction is being squashed (branch/jump redirect)
- rd_id  in  5  destination register index
- rs1_id  in  5  source 1 index
- rs2_id  in  5  source 2 index
- rs1_used_id  in  1  instruction reads rs1
- rs2_used_id  in  1  instruction reads rs2
- rs1_fpu_id  in  1  rs1 is read from the FP file (1) or the integer file (0)
- rs2_fpu_id  in  1  rs2 is read from the FP file (1) or the integer file (0)
- regwrite_id  in  2  01 = writes integer file, 10 = writes FP file, 00/11 = no write
- memread_id  in  1  instruction is a load (lw/flw)
- alu_op_id  in  2  11 = FPU operation
- stall_id  out  1  hold PC and IF/ID; insert bubble into ID/EX
- issue_id  out  1  ID instruction advances this cycle
- busy_int  out  32  integer register has a pending multi-cycle write
- busy_fp  out  32  FP register has a pending multi-cycle write

Behaviour:
- State: cnt_int[0..31] and cnt_fp[0..31], each CW bits, unsigned. busy_*[i] = (cnt_*[i] != 0).
- Reset: all counters 0, so busy_int = busy_fp = 0. stall_id = 0 and issue_id = 0 while rst is high. Reset mid-operation discards all pending entries.
- Latency class of the ID instruction:
  - memread_id=1 gives L = LOAD_LAT.
  - Otherwise alu_op_id=11 gives L = FPU_LAT.
  - Otherwise L = 1 (untracked).
  - memread takes priority.
- Destination file: dst_int = (regwrite_id==01 && rd_id!=0); dst_fp = (regwrite_id==10). Integer x0 is never tracked.
- RAW (combinational):
  - src1 hazard = rs1_used_id && (rs1_fpu_id ? cnt_fp[rs1_id] : cnt_int[rs1_id]) != 0.
  - src2 hazard is the same with rs2.
  - An rs1_fpu_id=0 read of x0 never hazards.
- WAW (combinational): hazard when the destination counter > L-1. This keeps writebacks in order; a shorter op never overtakes a longer pending one.
- Outputs: stall_id = valid_id && !flush_id && !rst && (RAW || WAW). issue_id = valid_id && !flush_id && !rst && !stall_id.
- Counter update, each clock:
  - Every nonzero counter decrements by 1.
  - On issue_id with dst_int/dst_fp and L >= 2, the destination counter loads L-1. The load overrides the decrement for that register in the same cycle.
- Stall timing: a consumer issued k cycles after the producer stalls while k < L. For L=1 there is never a stall.
- Flush: flush_id suppresses issue and stall for the ID instruction only. Counters of already-issued instructions keep counting; they are not cleared.
- No combinational path from the counters' next state to stall_id. stall_id depends only on current counters and ID inputs.

Test Plan:
- Reset with valid_id=1 and a hazard pattern forced -> stall_id=0, issue_id=0, busy_int=busy_fp=0. After release, all busy bits read 0.
- Load-use, default params:
  - Stimulus: lw x5 (regwrite=01, memread=1) issues at t; at t+1 an add reads rs1=x5.
  - t+1: busy_int[5]=1, stall_id=1, issue_id=0.
  - t+2: stall_id=0, issue_id=1, busy_int[5]=0.
- FPU chain:
  - Stimulus: fadd f3 (alu_op=11, regwrite=10) issues at t; fmul reads rs2=f3 with rs2_fpu_id=1.
  - Stalls at t+1..t+3; issues at t+4 (FPU_LAT=4).
  - A reader with rs2_fpu_id=0 (x3) does not stall.
- WAW:
  - Stimulus: fadd f7 at t; at t+1 flw f7 (L=2).
  - cnt_fp[7]=3 > 1, so stall. Stalls through t+2; issues at t+3, when cnt_fp[7]=1.
- x0 and flush:
  - lw x0 issues -> busy_int[0] stays 0.
  - Hazardous instruction with flush_id=1 -> stall_id=0, issue_id=0. An older pending counter continues decrementing.
- Reset mid-flight: issue fadd f1, assert rst at t+1 -> busy_fp[1]=0 at t+2. A dependent instruction after reset issues without stall.
